// File: rtl/osiris_video_pkg.sv
// Shared video types and sizing helpers.
// Used by the linebuffer fill controller.
package osiris_video_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_DATA,
        ST_DONE
    } fill_state_e;

    localparam int DEF_ADDRESS_WIDTH  = 32;
    localparam int DEF_DISPLAY_WIDTH  = 640;
    localparam int DEF_DISPLAY_HEIGHT = 480;

    function automatic int line_words(input int w);
        return w / 4;
    endfunction

    function automatic int lb_aw(input int w);
        return $clog2(w / 4) + 1;
    endfunction

endpackage

// File: rtl/edge_det.sv
// Registered rise/fall pulse detector.
// Each pulse lasts one clock, one cycle after the input edge.
module edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic sig_i,
    output logic rise_o,
    output logic fall_o
);

    logic prev_q;
    logic rise_q;
    logic fall_q;

    // Remember last level and register the edge pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            prev_q <= sig_i;
            rise_q <= sig_i & ~prev_q;
            fall_q <= ~sig_i & prev_q;
        end
    end

    assign rise_o = rise_q;
    assign fall_o = fall_q;

endmodule

// File: rtl/lbuf_fill_ctrl.sv
// Linebuffer fill controller: fetches one display line per
// horizontal blank into the bank the display is not reading.
module lbuf_fill_ctrl
    import osiris_video_pkg::*;
#(
    parameter int ADDRESS_WIDTH  = DEF_ADDRESS_WIDTH,
    parameter int DISPLAY_WIDTH  = DEF_DISPLAY_WIDTH,
    parameter int DISPLAY_HEIGHT = DEF_DISPLAY_HEIGHT
) (
    input  logic                             pclk,
    input  logic                             reset_n,
    input  logic                             enable,
    input  logic [ADDRESS_WIDTH-1:0]         fb_base,
    input  logic                             req_line,
    input  logic                             req_frame,
    output logic                             rd_req,
    output logic [ADDRESS_WIDTH-1:0]         rd_addr,
    input  logic                             rd_gnt,
    input  logic                             rd_valid,
    input  logic [31:0]                      rd_data,
    output logic                             lb_we,
    output logic [lb_aw(DISPLAY_WIDTH)-1:0]  lb_waddr,
    output logic [31:0]                      lb_wdata,
    output logic                             disp_bank,
    output logic                             underrun,
    input  logic                             underrun_clr,
    output logic                             busy
);

    localparam int LINE_WORDS = line_words(DISPLAY_WIDTH);
    localparam int LB_AW      = lb_aw(DISPLAY_WIDTH);
    localparam int IW         = LB_AW - 1;
    localparam int LNW        = (DISPLAY_HEIGHT > 1) ?
                                $clog2(DISPLAY_HEIGHT) : 1;

    localparam logic [IW-1:0]  LAST_IDX  = IW'(LINE_WORDS - 1);
    localparam logic [LNW-1:0] LAST_LINE = LNW'(DISPLAY_HEIGHT - 1);

    fill_state_e              state_q;
    logic [ADDRESS_WIDTH-1:0] rd_addr_q;
    logic [ADDRESS_WIDTH-1:0] frame_base_q;
    logic [LNW-1:0]           next_line_q;
    logic [IW-1:0]            word_idx_q;
    logic                     disp_bank_q;
    logic                     line_ready_q;
    logic                     underrun_q;

    logic                     line_rise;
    logic                     line_fall;
    logic                     frame_rise;
    logic                     frame_fall;
    logic                     beat;
    logic [ADDRESS_WIDTH-1:0] base_d;
    logic [ADDRESS_WIDTH-1:0] line_off_d;

    edge_det u_line_edge (
        .clk    (pclk),
        .rst_n  (reset_n),
        .sig_i  (req_line),
        .rise_o (line_rise),
        .fall_o (line_fall)
    );

    edge_det u_frame_edge (
        .clk    (pclk),
        .rst_n  (reset_n),
        .sig_i  (req_frame),
        .rise_o (frame_rise),
        .fall_o (frame_fall)
    );

    // Line 0 uses the live base, later lines the latched one.
    assign base_d     = (next_line_q == '0) ? fb_base : frame_base_q;
    assign line_off_d = ADDRESS_WIDTH'(next_line_q) *
                        ADDRESS_WIDTH'(DISPLAY_WIDTH);
    assign beat       = (state_q == ST_DATA) & rd_valid;

    // Fetch FSM plus bank swap, underrun and line tracking.
    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            rd_addr_q    <= '0;
            frame_base_q <= '0;
            next_line_q  <= '0;
            word_idx_q   <= '0;
            disp_bank_q  <= 1'b0;
            line_ready_q <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            if (underrun_clr) begin
                underrun_q <= 1'b0;
            end
            unique case (state_q)
                ST_IDLE: begin
                    if (line_rise && enable) begin
                        state_q   <= ST_REQ;
                        rd_addr_q <= base_d + line_off_d;
                        if (next_line_q == '0) begin
                            frame_base_q <= fb_base;
                        end
                    end
                end
                ST_REQ: begin
                    word_idx_q <= '0;
                    if (rd_gnt) begin
                        state_q <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (beat) begin
                        if (word_idx_q == LAST_IDX) begin
                            state_q    <= ST_DONE;
                            word_idx_q <= '0;
                        end else begin
                            word_idx_q <= word_idx_q + 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    line_ready_q <= 1'b1;
                    state_q      <= ST_IDLE;
                    if (next_line_q == LAST_LINE) begin
                        next_line_q <= '0;
                    end else begin
                        next_line_q <= next_line_q + 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
            if (line_rise && state_q != ST_IDLE) begin
                underrun_q <= 1'b1;
            end
            if (line_fall) begin
                if (line_ready_q) begin
                    disp_bank_q  <= ~disp_bank_q;
                    line_ready_q <= 1'b0;
                end else begin
                    underrun_q <= 1'b1;
                end
            end
            if (frame_rise) begin
                next_line_q <= '0;
            end
        end
    end

    assign rd_req    = (state_q == ST_REQ);
    assign rd_addr   = rd_addr_q;
    assign busy      = (state_q != ST_IDLE);
    assign disp_bank = disp_bank_q;
    assign underrun  = underrun_q;
    assign lb_we     = beat;
    assign lb_waddr  = beat ? {~disp_bank_q, word_idx_q} : '0;
    assign lb_wdata  = beat ? rd_data : '0;

endmodule

// File: tb/tb_lbuf_fill_ctrl.sv
// Scoreboard bench for lbuf_fill_ctrl with a line-level
// reference model; short frame height keeps wraps reachable.
module tb_lbuf_fill_ctrl;

    localparam int AW   = 32;
    localparam int W    = 640;
    localparam int H    = 6;
    localparam int LW   = W / 4;
    localparam int IW   = $clog2(LW);
    localparam int LBAW = IW + 1;

    logic            pclk = 1'b0;
    logic            reset_n = 1'b0;
    logic            enable = 1'b0;
    logic [AW-1:0]   fb_base = '0;
    logic            req_line = 1'b0;
    logic            req_frame = 1'b0;
    logic            rd_req;
    logic [AW-1:0]   rd_addr;
    logic            rd_gnt = 1'b0;
    logic            rd_valid = 1'b0;
    logic [31:0]     rd_data = '0;
    logic            lb_we;
    logic [LBAW-1:0] lb_waddr;
    logic [31:0]     lb_wdata;
    logic            disp_bank;
    logic            underrun;
    logic            underrun_clr = 1'b0;
    logic            busy;

    lbuf_fill_ctrl #(
        .ADDRESS_WIDTH  (AW),
        .DISPLAY_WIDTH  (W),
        .DISPLAY_HEIGHT (H)
    ) dut (
        .pclk         (pclk),
        .reset_n      (reset_n),
        .enable       (enable),
        .fb_base      (fb_base),
        .req_line     (req_line),
        .req_frame    (req_frame),
        .rd_req       (rd_req),
        .rd_addr      (rd_addr),
        .rd_gnt       (rd_gnt),
        .rd_valid     (rd_valid),
        .rd_data      (rd_data),
        .lb_we        (lb_we),
        .lb_waddr     (lb_waddr),
        .lb_wdata     (lb_wdata),
        .disp_bank    (disp_bank),
        .underrun     (underrun),
        .underrun_clr (underrun_clr),
        .busy         (busy)
    );

    always #5 pclk = ~pclk;

    int n_chk = 0;
    int n_fail = 0;

    logic [AW-1:0]   aq[$];
    logic [LBAW-1:0] wa_q[$];
    logic [31:0]     wd_q[$];

    int            m_line;
    int            m_idx;
    logic [AW-1:0] m_base;
    bit            m_bank;
    bit            m_ready;
    bit            m_under;
    bit            m_fetch;
    bit            m_en;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: compare every presented request and write.
    always @(negedge pclk) begin
        if (reset_n === 1'b1) begin
            if (rd_req) begin
                if (aq.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL rd_req: got 1 expected 0");
                end else begin
                    chk("rd_addr", rd_addr, aq[0]);
                    if (rd_gnt) aq.pop_front();
                end
            end
            if (lb_we) begin
                if (wa_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL lb_we: got 1 expected 0 (addr %0h)",
                             lb_waddr);
                end else begin
                    chk("lb_waddr", lb_waddr, wa_q.pop_front());
                    chk("lb_wdata", lb_wdata, wd_q.pop_front());
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge pclk);
        #1;
    endtask

    task automatic model_reset();
        m_line  = 0;
        m_idx   = 0;
        m_base  = '0;
        m_bank  = 1'b0;
        m_ready = 1'b0;
        m_under = 1'b0;
        m_fetch = 1'b0;
        aq.delete();
        wa_q.delete();
        wd_q.delete();
    endtask

    task automatic line_rise(input int gdly);
        int k;
        req_line = 1'b1;
        if (m_en && !m_fetch) begin
            if (m_line == 0) m_base = fb_base;
            aq.push_back(m_base + AW'(m_line) * AW'(W));
            m_fetch = 1'b1;
            m_idx   = 0;
            k = 0;
            do begin
                tick(1);
                k++;
            end while (!rd_req && k < 20);
            if (!rd_req) begin
                n_chk++;
                n_fail++;
                $display("FAIL rd_req_timeout: got 0 expected 1");
            end else begin
                tick(gdly);
                rd_gnt = 1'b1;
                tick(1);
                rd_gnt = 1'b0;
            end
        end else begin
            tick(10);
            chk("busy_no_fetch", busy, 0);
        end
    endtask

    task automatic beats(input int n, input bit frame);
        for (int i = 0; i < n; i++) begin
            if (!frame && $urandom_range(3) == 0) begin
                rd_valid = 1'b0;
                tick(int'($urandom_range(2)) + 1);
            end
            rd_valid = 1'b1;
            rd_data  = $urandom;
            if (m_fetch) begin
                wa_q.push_back({~m_bank, IW'(m_idx)});
                wd_q.push_back(rd_data);
                m_idx++;
            end
            if (frame && i == n - 1) req_frame = 1'b1;
            tick(1);
        end
        rd_valid = 1'b0;
        if (m_fetch && m_idx == LW) begin
            m_fetch = 1'b0;
            m_ready = 1'b1;
            m_line  = frame ? 0 : (m_line + 1) % H;
        end
        tick(3);
        req_frame = 1'b0;
        chk("busy", busy, m_fetch);
    endtask

    task automatic line_fall();
        req_line = 1'b0;
        if (m_ready) begin
            m_bank  = ~m_bank;
            m_ready = 1'b0;
        end else begin
            m_under = 1'b1;
        end
        tick(3);
        chk("disp_bank", disp_bank, m_bank);
        chk("underrun", underrun, m_under);
    endtask

    task automatic clr_under();
        underrun_clr = 1'b1;
        tick(1);
        underrun_clr = 1'b0;
        m_under = 1'b0;
        tick(1);
        chk("underrun_clr", underrun, 0);
    endtask

    task automatic chk_reset_outs();
        chk("rst_rd_req", rd_req, 0);
        chk("rst_rd_addr", rd_addr, 0);
        chk("rst_lb_we", lb_we, 0);
        chk("rst_lb_waddr", lb_waddr, 0);
        chk("rst_lb_wdata", lb_wdata, 0);
        chk("rst_disp_bank", disp_bank, 0);
        chk("rst_underrun", underrun, 0);
        chk("rst_busy", busy, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        m_en = 1'b1;
        tick(2);
        chk_reset_outs();
        reset_n = 1'b1;
        enable  = 1'b1;
        fb_base = 32'h1000;
        tick(2);

        line_rise(3);
        beats(LW, 0);
        line_fall();

        fb_base = 32'h5555;
        line_rise(1);
        beats(LW, 0);
        line_fall();

        line_rise(2);
        beats(100, 0);
        line_fall();
        beats(LW - 100, 0);
        clr_under();

        line_rise(0);
        beats(LW, 1);
        fb_base = 32'h8000;
        line_fall();
        line_rise(1);
        beats(LW, 0);
        line_fall();

        line_rise(2);
        beats(50, 0);
        reset_n  = 1'b0;
        req_line = 1'b0;
        rd_valid = 1'b1;
        rd_data  = $urandom;
        #1;
        chk_reset_outs();
        model_reset();
        tick(1);
        reset_n = 1'b1;
        beats(20, 0);
        fb_base = 32'h2000;
        line_rise(1);
        beats(LW, 0);
        line_fall();

        line_rise(1);
        beats(80, 0);
        enable = 1'b0;
        m_en   = 1'b0;
        beats(LW - 80, 0);
        line_fall();
        line_rise(0);
        line_fall();
        clr_under();
        enable = 1'b1;
        m_en   = 1'b1;

        for (int i = 0; i < 14; i++) begin
            fb_base = $urandom;
            line_rise(int'($urandom_range(4)));
            beats(LW, $urandom_range(3) == 0);
            line_fall();
        end

        tick(4);
        chk("addr_queue_left", aq.size(), 0);
        chk("write_queue_left", wa_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
